// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational imem into IF/ID,
// handles stall, redirect/flush and end-of-memory halt. Optional macro: FETCH_ALIGN_CHECK_EN.
module fetch_controller #(
    parameter int unsigned IMEM_BYTES = 512,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_out,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        halted,
    output logic        fetch_err
);
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_e;

    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        err_set;
    logic        misaligned;
    logic [31:0] redir_tgt;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fetch_err_q;
    assign misaligned = (redirect_pc[1:0] != 2'b00);
    assign redir_tgt  = redirect_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fetch_err_q <= 1'b0;
        else if (err_set) fetch_err_q <= 1'b1;
    end
    assign fetch_err = fetch_err_q;
`else
    // Low address bits are dropped, so a misaligned target lands on its containing word.
    assign misaligned = 1'b0;
    assign redir_tgt  = redirect_pc & ~32'h3;
    assign fetch_err  = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        err_set      = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect_valid) begin
                    ifid_valid_d = 1'b0;
                    pc_d         = redir_tgt;
                    if (misaligned) begin
                        state_d = HALT;
                        err_set = 1'b1;
                    end else begin
                        ifid_instr_d = 32'h0;
                    end
                end else if (stall) begin
                    state_d = RUN;
                end else if (pc_q > LAST_PC) begin
                    state_d      = HALT;
                    ifid_valid_d = 1'b0;
                end else begin
                    ifid_instr_d = imem_instr;
                    ifid_pc_d    = pc_q;
                    ifid_pc4_d   = pc_q + 32'd4;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_q + 32'd4;
                end
            end
            HALT: begin
                ifid_valid_d = 1'b0;
                if (redirect_valid) begin
                    if (misaligned) begin
                        pc_d    = redir_tgt;
                        err_set = 1'b1;
                    end else if (redir_tgt <= LAST_PC) begin
                        state_d = RUN;
                        pc_d    = redir_tgt;
                    end
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= 32'h0;
            ifid_pc_q    <= 32'h0;
            ifid_pc4_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

    assign pc_out     = pc_q;
    assign ifid_valid = ifid_valid_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign halted     = (state_q == HALT);
endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: reset flow, stall, redirect+stall, end-of-memory halt,
// misaligned redirect (both builds of FETCH_ALIGN_CHECK_EN) and asynchronous reset.
module tb_fetch_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_out;
    logic [31:0] imem_instr;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic        halted;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:127];

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    assign imem_instr = (pc_out < 32'd512) ? mem[pc_out[8:2]] : 32'hDEAD_BEEF;

    fetch_controller #(.IMEM_BYTES(512), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .pc_out(pc_out), .imem_instr(imem_instr),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .ifid_pc4(ifid_pc4), .halted(halted), .fetch_err(fetch_err)
    );

    // {halted, fetch_err, ifid_valid, pc_out, ifid_instr, ifid_pc, ifid_pc4}
    function automatic logic [130:0] snap();
        return {halted, fetch_err, ifid_valid, pc_out, ifid_instr, ifid_pc, ifid_pc4};
    endfunction

    function automatic logic [34:0] ctl();
        return {halted, fetch_err, ifid_valid, pc_out};
    endfunction

    task automatic test_reset();
        logic [130:0] exp;
        @(negedge clk);
        exp = '0;
        total++;
        if (snap() !== exp) begin bad++; $display("FAIL reset_values: got %h want %h", snap(), exp); end
        rst = 1'b0;
        @(negedge clk);
        exp = '0;
        total++;
        if (snap() !== exp) begin bad++; $display("FAIL boot_cycle: got %h want %h", snap(), exp); end
        @(negedge clk);
        exp = {3'b001, 32'h4, 32'h24010002, 32'h0, 32'h4};
        total++;
        if (snap() !== exp) begin bad++; $display("FAIL first_fetch: got %h want %h", snap(), exp); end
        @(negedge clk);
        exp = {3'b001, 32'h8, 32'h24020001, 32'h4, 32'h8};
        total++;
        if (snap() !== exp) begin bad++; $display("FAIL second_fetch: got %h want %h", snap(), exp); end
    endtask

    task automatic test_stall();
        logic [130:0] exp;
        stall = 1'b1;
        exp = {3'b001, 32'h8, 32'h24020001, 32'h4, 32'h8};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (snap() !== exp) begin bad++; $display("FAIL stall_hold_%0d: got %h want %h", i, snap(), exp); end
        end
        stall = 1'b0;
        @(negedge clk);
        exp = {3'b001, 32'hC, 32'hA000_0008, 32'h8, 32'hC};
        total++;
        if (snap() !== exp) begin bad++; $display("FAIL stall_release: got %h want %h", snap(), exp); end
    endtask

    task automatic test_redirect_stall();
        logic [130:0] exp;
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h1C;
        @(negedge clk);
        stall = 1'b0; redirect_valid = 1'b0;
        exp = {3'b000, 32'h1C, 32'h0, 32'h8, 32'hC};
        total++;
        if (snap() !== exp) begin bad++; $display("FAIL redir_flush: got %h want %h", snap(), exp); end
        @(negedge clk);
        exp = {3'b001, 32'h20, 32'h0041_1020, 32'h1C, 32'h20};
        total++;
        if (snap() !== exp) begin bad++; $display("FAIL redir_target: got %h want %h", snap(), exp); end
    endtask

    task automatic test_end_of_mem();
        logic [130:0] exp;
        logic [34:0]  cexp;
        redirect_valid = 1'b1; redirect_pc = 32'h1FC;
        @(negedge clk);
        redirect_valid = 1'b0;
        cexp = {3'b000, 32'h1FC};
        total++;
        if (ctl() !== cexp) begin bad++; $display("FAIL eom_redirect: got %h want %h", ctl(), cexp); end
        @(negedge clk);
        exp = {3'b001, 32'h200, 32'hA000_01FC, 32'h1FC, 32'h200};
        total++;
        if (snap() !== exp) begin bad++; $display("FAIL eom_last_word: got %h want %h", snap(), exp); end
        @(negedge clk);
        exp = {3'b100, 32'h200, 32'hA000_01FC, 32'h1FC, 32'h200};
        total++;
        if (snap() !== exp) begin bad++; $display("FAIL eom_halt: got %h want %h", snap(), exp); end
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        cexp = {3'b100, 32'h200};
        total++;
        if (ctl() !== cexp) begin bad++; $display("FAIL halt_oob_ignored: got %h want %h", ctl(), cexp); end
        redirect_pc = 32'h0;
        @(negedge clk);
        redirect_valid = 1'b0;
        cexp = {3'b000, 32'h0};
        total++;
        if (ctl() !== cexp) begin bad++; $display("FAIL halt_exit: got %h want %h", ctl(), cexp); end
        @(negedge clk);
        exp = {3'b001, 32'h4, 32'h24010002, 32'h0, 32'h4};
        total++;
        if (snap() !== exp) begin bad++; $display("FAIL resume_fetch: got %h want %h", snap(), exp); end
    endtask

    task automatic test_misaligned();
        logic [130:0] exp;
        logic [34:0]  cexp;
        redirect_valid = 1'b1; redirect_pc = 32'h0A;
        @(negedge clk);
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        cexp = {3'b110, 32'h0A};
`else
        cexp = {3'b000, 32'h08};
`endif
        total++;
        if (ctl() !== cexp) begin bad++; $display("FAIL misalign_redirect: got %h want %h", ctl(), cexp); end
        @(negedge clk);
`ifdef FETCH_ALIGN_CHECK_EN
        cexp = {3'b110, 32'h0A};
        total++;
        if (ctl() !== cexp) begin bad++; $display("FAIL misalign_stays_halted: got %h want %h", ctl(), cexp); end
`else
        exp = {3'b001, 32'hC, 32'hA000_0008, 32'h8, 32'hC};
        total++;
        if (snap() !== exp) begin bad++; $display("FAIL misalign_continue: got %h want %h", snap(), exp); end
`endif
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        exp = {1'b0, EXP_ERR, 1'b1, 32'h14, 32'hA000_0010, 32'h10, 32'h14};
        total++;
        if (snap() !== exp) begin bad++; $display("FAIL fetch_at_10: got %h want %h", snap(), exp); end
    endtask

    task automatic test_async_reset();
        logic [130:0] exp;
        #2;
        rst = 1'b1;
        #1;
        exp = '0;
        total++;
        if (snap() !== exp) begin bad++; $display("FAIL async_reset: got %h want %h", snap(), exp); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (snap() !== exp) begin bad++; $display("FAIL reboot_cycle: got %h want %h", snap(), exp); end
        @(negedge clk);
        exp = {3'b001, 32'h4, 32'h24010002, 32'h0, 32'h4};
        total++;
        if (snap() !== exp) begin bad++; $display("FAIL reboot_fetch: got %h want %h", snap(), exp); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 | (32'(i) << 2);
        mem[0] = 32'h2401_0002;
        mem[1] = 32'h2402_0001;
        mem[7] = 32'h0041_1020;
        test_reset();
        test_stall();
        test_redirect_stall();
        test_end_of_mem();
        test_misaligned();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer for the single-cycle/pipelined processor. Owns the program counter, drives the byte address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. Handles stall, branch/jump redirect with flush, and the end-of-memory halt. Sits between the instruction memory and the decode stage.

## Interface

Parameters:
- IMEM_BYTES, 512, instruction memory size in bytes (multiple of 4)
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- pc_out  out  32  byte address to instruction memory
- imem_instr  in  32  word returned combinationally for pc_out
- stall  in  1  hold PC and IF/ID contents this cycle
- redirect_valid  in  1  load redirect_pc and flush IF/ID
- redirect_pc  in  32  branch/jump target byte address
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_instr  out  32  fetched instruction
- ifid_pc  out  32  address of ifid_instr
- ifid_pc4  out  32  ifid_pc + 4
- halted  out  1  fetch stopped (state HALT)
- fetch_err  out  1  sticky misaligned-redirect flag

## Operation

- Reset values: pc = RESET_PC, state BOOT, ifid_valid 0, ifid_instr/ifid_pc/ifid_pc4 0, halted 0, fetch_err 0.
- pc_out = pc register directly (no combinational path from inputs).
- In-range: pc <= IMEM_BYTES-4, full 32-bit unsigned compare.
- States:
  - BOOT: one cycle after reset release; ifid_valid stays 0, pc holds; -> RUN unconditionally (redirect_valid ignored).
  - RUN, priority order:
    1. redirect_valid: pc <= target, ifid_valid <= 0, ifid_instr <= 0; stall ignored.
    2. stall: pc and all ifid_* hold.
    3. pc out of range: -> HALT, ifid_valid <= 0, pc holds.
    4. Otherwise: ifid_instr <= imem_instr, ifid_pc <= pc, ifid_pc4 <= pc+4, ifid_valid <= 1, pc <= pc+4.
  - HALT: halted = 1, ifid_valid 0, pc holds. Exits only via redirect_valid with in-range target (-> RUN, pc <= target) or rst. An out-of-range redirect in HALT is ignored.
- pc+4 is modulo 2^32. The range check catches any overflow before a wrapped fetch.
- Redirect to an out-of-range target from RUN is accepted. The next cycle's range check sends the block to HALT.

## Timing

- Fetch latency 1 cycle: address on pc_out in cycle N -> word on ifid_* after edge N.
- Redirect asserted in cycle N: pc_out = target in N+1 with ifid_valid 0. Target instruction is valid in IF/ID in N+2.
- Stall is level-sensitive. Each stalled cycle freezes everything; no instruction is lost or duplicated.
- Simultaneous stall + redirect: redirect wins, IF/ID flushed.
- rst asserted mid-operation: all outputs go to reset values immediately, without waiting for clk. First valid fetch comes 2 edges after release (BOOT, then RUN).

## Configuration

- FETCH_ALIGN_CHECK_EN defined:
  - redirect_pc[1:0] != 0 in RUN or HALT -> state HALT, pc <= redirect_pc (recorded for debug), ifid_valid <= 0.
  - fetch_err <= 1, sticky until rst.
- FETCH_ALIGN_CHECK_EN undefined:
  - pc <= {redirect_pc[31:2], 2'b00}, otherwise normal redirect.
  - fetch_err tied to 0.

## Test plan

- Reset flow: memory preloaded with words 0x24010002 @0, 0x24020001 @4; release rst -> BOOT cycle ifid_valid 0, then ifid_instr 0x24010002 / ifid_pc 0 / ifid_pc4 4, next edge 0x24020001 / pc 4.
- Stall: assert stall 3 cycles while ifid_pc = 4 -> ifid_* and pc_out (8) frozen for 3 cycles; after release ifid_pc 8 with no skip or repeat.
- Redirect + stall together to 0x1C -> next cycle pc_out 0x1C, ifid_valid 0, ifid_instr 0; following cycle ifid_instr 0x00411020, ifid_pc 0x1C.
- End of memory: IMEM_BYTES 512, redirect to 0x1FC -> word at 0x1FC fetched valid; next cycle halted 1, ifid_valid 0, pc_out 0x200. Redirect to 0x0 -> halted 0, fetch resumes at 0.
- Misaligned redirect to 0x0A: with FETCH_ALIGN_CHECK_EN -> halted 1, fetch_err 1, pc_out 0x0A. Without it -> pc_out 0x08, fetch_err 0, fetch continues.
- Async reset mid-run at ifid_pc 0x10: assert rst between edges -> all outputs 0 and pc_out RESET_PC before the next clk edge.
